// File: rtl/calc_pkg.sv
// Shared calculator definitions: key tokens, radix and operand-builder states.
// Pure declarations, no timing; no flow control.
package calc_pkg;

    localparam int TOKEN_W = 4;
    localparam int RADIX   = 10;

    localparam logic [TOKEN_W-1:0] TOK_ADD = 4'hA;
    localparam logic [TOKEN_W-1:0] TOK_SUB = 4'hB;
    localparam logic [TOKEN_W-1:0] TOK_MUL = 4'hC;
    localparam logic [TOKEN_W-1:0] TOK_DIV = 4'hD;
    localparam logic [TOKEN_W-1:0] TOK_EQ  = 4'hE;
    localparam logic [TOKEN_W-1:0] TOK_CLR = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        BUILD,
        EMIT
    } state_t;

    function automatic logic is_digit(input logic [TOKEN_W-1:0] t);
        return t <= 4'd9;
    endfunction

endpackage

// File: rtl/number_accumulator_if.sv
// Token in / operand record out bundle between keypad decoder and stack stage.
// No logic; master drives tokens and takes records, slave is the accumulator.
interface number_accumulator_if #(
    parameter int WIDTH = 32
);
    logic                         tok_valid;
    logic [calc_pkg::TOKEN_W-1:0] tok;
    logic                         tok_ready;
    logic                         num_valid;
    logic                         num_ready;
    logic [WIDTH-1:0]             number;
    logic [calc_pkg::TOKEN_W-1:0] op;
    logic                         num_present;
    logic                         overflow;

    modport master (
        output tok_valid, tok, num_ready,
        input  tok_ready, num_valid, number, op, num_present, overflow
    );

    modport slave (
        input  tok_valid, tok, num_ready,
        output tok_ready, num_valid, number, op, num_present, overflow
    );
endinterface

// File: rtl/number_acc_mac.sv
// Multiply-accumulate step acc*RADIX+d on the magnitude with signed range check.
// Combinational, zero latency; no flow control.
module number_acc_mac
    import calc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]   acc,
    input  logic [TOKEN_W-1:0] d,
    input  logic               sign,
    output logic [WIDTH-1:0]   next,
    output logic               ovf
);
    localparam int XW = WIDTH + 4;

    logic [XW-1:0] wide;
    logic [XW-1:0] limit;

    // Extra 4 bits hold acc*10 even when acc sits at the negative-range limit.
    assign wide  = XW'(acc) * XW'(RADIX) + XW'(d);
    assign limit = sign ? (XW'(1) << (WIDTH - 1))
                        : ((XW'(1) << (WIDTH - 1)) - XW'(1));
    assign ovf   = wide > limit;
    assign next  = wide[WIDTH-1:0];
endmodule

// File: rtl/number_accumulator.sv
// Builds a signed decimal operand from key tokens, emits {number, op} per operator/clear.
// Token accepted at edge N shows at N+1; record valid from N+1 after an operator.
// tok_ready low while a record waits for num_ready; NUMBER_ACC_NEG_EN enables unary minus.
module number_accumulator
    import calc_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MAX_DIGITS = 9
) (
    input  logic                 clk,
    input  logic                 reset,
    number_accumulator_if.slave  bus
);
    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

    state_t               state;
    logic [WIDTH-1:0]     acc;
    logic [CNT_W-1:0]     cnt;
    logic                 sign;
    logic                 ovf;
    logic                 tok_ready_r;
    logic                 num_valid_r;
    logic [WIDTH-1:0]     number_r;
    logic [TOKEN_W-1:0]   op_r;
    logic                 present_r;
    logic                 overflow_r;

    logic [WIDTH-1:0]     mac_next;
    logic                 mac_ovf;
    logic                 tok_acc;

    number_acc_mac #(.WIDTH(WIDTH)) u_mac (
        .acc  (acc),
        .d    (bus.tok),
        .sign (sign),
        .next (mac_next),
        .ovf  (mac_ovf)
    );

    assign tok_acc = bus.tok_valid && tok_ready_r;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            acc         <= '0;
            cnt         <= '0;
            sign        <= 1'b0;
            ovf         <= 1'b0;
            tok_ready_r <= 1'b1;
            num_valid_r <= 1'b0;
            number_r    <= '0;
            op_r        <= '0;
            present_r   <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            case (state)
                IDLE, BUILD: begin
                    if (tok_acc) begin
                        if (is_digit(bus.tok)) begin
                            // Dropped digits leave acc intact but mark the operand.
                            if (cnt == CNT_W'(MAX_DIGITS) || mac_ovf) begin
                                ovf <= 1'b1;
                            end else begin
                                acc <= mac_next;
                                cnt <= cnt + CNT_W'(1);
                            end
                            state <= BUILD;
`ifdef NUMBER_ACC_NEG_EN
                        end else if (state == IDLE && bus.tok == TOK_SUB) begin
                            sign <= ~sign;
`endif
                        end else begin
                            if (bus.tok == TOK_CLR) begin
                                number_r   <= '0;
                                present_r  <= 1'b0;
                                overflow_r <= 1'b0;
                            end else begin
                                number_r   <= sign ? -acc : acc;
                                present_r  <= (state == BUILD);
                                overflow_r <= ovf;
                            end
                            op_r        <= bus.tok;
                            num_valid_r <= 1'b1;
                            tok_ready_r <= 1'b0;
                            state       <= EMIT;
                        end
                    end
                end
                EMIT: begin
                    if (bus.num_ready) begin
                        state       <= IDLE;
                        acc         <= '0;
                        cnt         <= '0;
                        sign        <= 1'b0;
                        ovf         <= 1'b0;
                        num_valid_r <= 1'b0;
                        tok_ready_r <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.tok_ready   = tok_ready_r;
    assign bus.num_valid   = num_valid_r;
    assign bus.number      = number_r;
    assign bus.op          = op_r;
    assign bus.num_present = present_r;
    assign bus.overflow    = overflow_r;
endmodule
